// File: rtl/video_timing_pkg.sv
// Shared raster-mode types and presets for the video timing generator family.
// Keeps one axis description (active/fp/sync/bp) so modes read the same everywhere.
package video_timing_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } axis_t;

    typedef struct packed {
        axis_t h;
        axis_t v;
    } mode_t;

    localparam mode_t MODE_640x480_60 = '{
        h: '{active: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48},
        v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33}
    };

    localparam mode_t MODE_800x600_60 = '{
        h: '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88},
        v: '{active: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23}
    };

    function automatic int unsigned axis_total(input axis_t a);
        return 32'(a.active) + 32'(a.fp) + 32'(a.sync) + 32'(a.bp);
    endfunction

endpackage

// File: rtl/fractional_clk_en.sv
// Phase accumulator that turns a fast clock into a PIXEL_MHZ/CLK_MHZ enable strobe
// and a roughly 50% duty derived clock. Freezes completely while en is low.
module fractional_clk_en #(
    parameter int CLK_MHZ   = 125,
    parameter int PIXEL_MHZ = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic pixel_en,
    output logic pixel_clk
);

    localparam int W_PH = $clog2(2 * CLK_MHZ);
    localparam logic [W_PH:0]   STEP    = (W_PH + 1)'(PIXEL_MHZ);
    localparam logic [W_PH:0]   MODULUS = (W_PH + 1)'(CLK_MHZ);
    localparam logic [W_PH-1:0] HALF    = W_PH'(CLK_MHZ / 2);

    logic [W_PH-1:0] phase;
    logic [W_PH-1:0] phase_nxt;
    logic [W_PH:0]   sum;
    logic            wrap;

    // Extra sum bit keeps phase + step from aliasing before the modulus compare.
    always_comb begin
        sum       = {1'b0, phase} + STEP;
        wrap      = (sum >= MODULUS);
        phase_nxt = wrap ? W_PH'(sum - MODULUS) : W_PH'(sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            pixel_en  <= 1'b0;
            pixel_clk <= 1'b0;
        end else if (en) begin
            phase     <= phase_nxt;
            pixel_en  <= wrap;
            pixel_clk <= (phase_nxt < HALF);
        end else begin
            pixel_en  <= 1'b0;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator in the fast clock domain (x/y, syncs, de, markers).
// Optional colour-bar pattern on red/green/blue when VIDEO_TIMING_GEN_PATTERN_EN is defined.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   CLK_MHZ    = 125,
    parameter int   PIXEL_MHZ  = 25,
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   W_COLOR    = 8,
    localparam axis_t       H_AXIS  = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)},
    localparam axis_t       V_AXIS  = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)},
    localparam int unsigned H_TOTAL = axis_total(H_AXIS),
    localparam int unsigned V_TOTAL = axis_total(V_AXIS),
    localparam int          W_X     = $clog2(H_TOTAL),
    localparam int          W_Y     = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               pixel_en,
    output logic               pixel_clk,
    output logic [W_X-1:0]     x,
    output logic [W_Y-1:0]     y,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [W_COLOR-1:0] red,
    output logic [W_COLOR-1:0] green,
    output logic [W_COLOR-1:0] blue
);

    if (PIXEL_MHZ < 1 || PIXEL_MHZ > CLK_MHZ / 2 || H_SYNC == 0 || V_SYNC == 0) begin : g_bad_cfg
        $fatal(1, "video_timing_gen: illegal pixel rate or zero-width sync");
    end

    localparam logic [W_X-1:0] X_LAST   = W_X'(H_TOTAL - 1);
    localparam logic [W_Y-1:0] Y_LAST   = W_Y'(V_TOTAL - 1);
    localparam int unsigned    HS_START = H_ACTIVE + H_FP;
    localparam int unsigned    HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned    VS_START = V_ACTIVE + V_FP;
    localparam int unsigned    VS_END   = V_ACTIVE + V_FP + V_SYNC;

    fractional_clk_en #(
        .CLK_MHZ   (CLK_MHZ),
        .PIXEL_MHZ (PIXEL_MHZ)
    ) u_clk_en (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pixel_en  (pixel_en),
        .pixel_clk (pixel_clk)
    );

    logic           adv;
    logic           running;
    logic [W_X-1:0] x_nxt;
    logic [W_Y-1:0] y_nxt;
    logic           de_nxt;
    logic           hs_on;
    logic           vs_on;

    // The first pixel after reset lands on (0,0) so it carries frame_start.
    always_comb begin
        adv   = en & pixel_en;
        x_nxt = x;
        y_nxt = y;
        if (adv) begin
            if (!running) begin
                x_nxt = '0;
                y_nxt = '0;
            end else if (x == X_LAST) begin
                x_nxt = '0;
                y_nxt = (y == Y_LAST) ? '0 : y + W_Y'(1);
            end else begin
                x_nxt = x + W_X'(1);
            end
        end
        de_nxt = (32'(x_nxt) < H_ACTIVE) && (32'(y_nxt) < V_ACTIVE);
        hs_on  = (32'(x_nxt) >= HS_START) && (32'(x_nxt) < HS_END);
        vs_on  = (32'(y_nxt) >= VS_START) && (32'(y_nxt) < VS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running     <= 1'b0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= adv && (x_nxt == '0);
            frame_start <= adv && (x_nxt == '0) && (y_nxt == '0);
            if (adv) begin
                running <= 1'b1;
                x       <= x_nxt;
                y       <= y_nxt;
                de      <= de_nxt;
                hsync   <= hs_on ? H_SYNC_POL : ~H_SYNC_POL;
                vsync   <= vs_on ? V_SYNC_POL : ~V_SYNC_POL;
            end
        end
    end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [31:0] bar_raw;
    logic [2:0]  bar;

    always_comb begin
        bar_raw = 32'(x_nxt) / BAR_W;
        bar     = (bar_raw > 32'd7) ? 3'd7 : bar_raw[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (adv) begin
            red   <= (de_nxt && bar[2]) ? '1 : '0;
            green <= (de_nxt && bar[1]) ? '1 : '0;
            blue  <= (de_nxt && bar[0]) ? '1 : '0;
        end
    end
`else
    assign red   = '0;
    assign green = '0;
    assign blue  = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small fractional-rate raster with mixed sync polarity.
// Reference is arithmetic on strobe/pixel counts; pattern expectations follow VIDEO_TIMING_GEN_PATTERN_EN.
module tb_video_timing_gen;

    localparam int   CLK = 100;
    localparam int   PIX = 40;
    localparam int   HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int   VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam logic HP = 1'b1;
    localparam logic VP = 1'b0;
    localparam int   WC = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          pixel_en, pixel_clk, de, hsync, vsync, line_start, frame_start;
    logic [4:0]    x;
    logic [3:0]    y;
    logic [WC-1:0] red, green, blue;

    video_timing_gen #(
        .CLK_MHZ(CLK), .PIXEL_MHZ(PIX),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(HP), .V_SYNC_POL(VP), .W_COLOR(WC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .pixel_en(pixel_en), .pixel_clk(pixel_clk),
        .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint n_en;
    int     pix_cnt;
    bit     m_pe, m_pclk, m_ls, m_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int px_of(input int cnt);
        return (cnt - 1) % HT;
    endfunction

    function automatic int py_of(input int cnt);
        return ((cnt - 1) / HT) % VT;
    endfunction

    task automatic model_reset();
        n_en = 0; pix_cnt = 0; m_pe = 0; m_pclk = 0; m_ls = 0; m_fs = 0;
    endtask

    task automatic check_all(input string tag);
        int mx, my, bar;
        bit mde, mhs, mvs;
        logic [WC-1:0] r, g, b;
        if (pix_cnt == 0) begin
            mx = 0; my = 0; mde = 0; mhs = !HP; mvs = !VP;
        end else begin
            mx  = px_of(pix_cnt);
            my  = py_of(pix_cnt);
            mde = (mx < HA) && (my < VA);
            mhs = (mx >= HA + HF && mx < HA + HF + HS) ? HP : !HP;
            mvs = (my >= VA + VF && my < VA + VF + VS) ? VP : !VP;
        end
        r = '0; g = '0; b = '0;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        bar = mx / (HA / 8);
        if (bar > 7) bar = 7;
        if (mde) begin
            r = ((bar & 4) != 0) ? '1 : '0;
            g = ((bar & 2) != 0) ? '1 : '0;
            b = ((bar & 1) != 0) ? '1 : '0;
        end
`else
        bar = 0;
`endif
        chk({tag, ".pixel_en"},    32'(pixel_en),    32'(m_pe));
        chk({tag, ".pixel_clk"},   32'(pixel_clk),   32'(m_pclk));
        chk({tag, ".x"},           32'(x),           32'(mx));
        chk({tag, ".y"},           32'(y),           32'(my));
        chk({tag, ".de"},          32'(de),          32'(mde));
        chk({tag, ".hsync"},       32'(hsync),       32'(mhs));
        chk({tag, ".vsync"},       32'(vsync),       32'(mvs));
        chk({tag, ".line_start"},  32'(line_start),  32'(m_ls));
        chk({tag, ".frame_start"}, 32'(frame_start), 32'(m_fs));
        chk({tag, ".rgb"},         {8'h0, red, green, blue}, {8'h0, r, g, b});
    endtask

    // One clock: advance the reference with the en seen at the edge, then compare mid-cycle.
    task automatic tick(input string tag);
        bit e;
        @(posedge clk);
        e = en;
        if (rst_n) begin
            m_ls = 0; m_fs = 0;
            if (e) begin
                if (m_pe) begin
                    pix_cnt++;
                    m_ls = (px_of(pix_cnt) == 0);
                    m_fs = m_ls && (py_of(pix_cnt) == 0);
                end
                n_en++;
                m_pe   = ((n_en * PIX) / CLK) != (((n_en - 1) * PIX) / CLK);
                m_pclk = ((n_en * PIX) % CLK) < (CLK / 2);
            end else begin
                m_pe = 0;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int win, total, guard;
        model_reset();
        rst_n = 1'b0; en = 1'b0;
        repeat (3) tick("reset");

        // Continuous run: 2-in-5 strobe density and 400 pulses in 1000 clk.
        rst_n = 1'b1; en = 1'b1;
        total = 0;
        for (int w = 0; w < 200; w++) begin
            win = 0;
            for (int k = 0; k < 5; k++) begin
                tick("run");
                win += int'(pixel_en);
            end
            total += win;
            chk("pe_window", 32'(win), 32'd2);
        end
        chk("pe_total", 32'(total), 32'd400);

        // Pause mid-line for 50 clk.
        guard = 0;
        while (!(pix_cnt > 0 && px_of(pix_cnt) == 8) && guard < 200) begin
            tick("seek_pause"); guard++;
        end
        chk("seek_pause_timeout", 32'(guard < 200), 32'd1);
        en = 1'b0;
        repeat (50) tick("paused");
        en = 1'b1;
        repeat (60) tick("resume");

        // Random enable pattern.
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 3) != 0);
            tick("rand_en");
        end
        en = 1'b1;

        // Async reset at x=10, y=3, then restart.
        guard = 0;
        while (!(pix_cnt > 0 && px_of(pix_cnt) == 10 && py_of(pix_cnt) == 3) && guard < 2000) begin
            tick("seek_reset"); guard++;
        end
        chk("seek_reset_timeout", 32'(guard < 2000), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_reset");
        repeat (4) tick("in_reset");
        rst_n = 1'b1;
        repeat (700) tick("after_reset");

        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 7) != 0);
            tick("rand_tail");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 timing generator that feeds the DVI/HDMI transmitter on the Gowin boards.
- Runs entirely in the fast serial-clock domain and produces a fractional pixel-enable strobe plus a derived pixel clock.
- Generates raster counters, hsync/vsync/de and line/frame markers for any resolution, porch set and sync polarity.
- Sits between the PLL output and DVI_TX_Top; lab_top consumes x/y.

Parameters:
- CLK_MHZ, 125, input clock frequency (integer MHz).
- PIXEL_MHZ, 25, pixel rate; must satisfy 1 <= PIXEL_MHZ <= CLK_MHZ/2.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- H_SYNC_POL, 0, asserted level of hsync (0 = active-low).
- V_SYNC_POL, 0, asserted level of vsync.
- W_COLOR, 8, bits per colour channel (pattern option only).
- Derived, not overridable: H_TOTAL = sum of the H_* values; V_TOTAL = sum of the V_* values; W_X = $clog2(H_TOTAL); W_Y = $clog2(V_TOTAL).

Ports:
- clk  in  1  serial/fast clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; when low, counters and phase freeze.
- pixel_en  out  1  one-clk strobe, one per pixel.
- pixel_clk  out  1  derived pixel clock for the rgb_clk input.
- x  out  W_X  horizontal count, 0..H_TOTAL-1.
- y  out  W_Y  vertical count, 0..V_TOTAL-1.
- de  out  1  high when x < H_ACTIVE and y < V_ACTIVE.
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL.
- vsync  out  1  vertical sync, polarity per V_SYNC_POL.
- line_start  out  1  one-clk pulse when x becomes 0.
- frame_start  out  1  one-clk pulse when x and y both become 0.
- red/green/blue  out  W_COLOR each  test pattern output; zero when the pattern option is off.

Behaviour:
- Reset (rst_n low, async): phase = 0, x = 0, y = 0, pixel_en = 0, pixel_clk = 0, de = 0, line_start = 0, frame_start = 0, colours = 0.
  - hsync = ~H_SYNC_POL and vsync = ~V_SYNC_POL (inactive levels).
  - Release mid-frame restarts the raster at (0,0).
- Phase accumulator, width $clog2(2*CLK_MHZ):
  - Each clk with en = 1: if phase + PIXEL_MHZ >= CLK_MHZ, phase <= phase + PIXEL_MHZ - CLK_MHZ and pixel_en <= 1.
  - Otherwise phase <= phase + PIXEL_MHZ and pixel_en <= 0.
  - Long-run strobe rate is exactly PIXEL_MHZ/CLK_MHZ.
- pixel_clk is registered as (next phase < CLK_MHZ/2). With integer ratios the duty cycle is ~50%; with fractional ratios the period jitters by at most one clk.
- Raster counters advance only on the cycle after pixel_en is asserted, i.e. counters are registered on the pixel_en pulse.
  - x wraps from H_TOTAL-1 to 0.
  - y increments only on x wrap, and wraps from V_TOTAL-1 to 0.
- All outputs are registered from next-state counter values, so x, y, de, hsync, vsync, line_start and frame_start are mutually coherent in the same cycle. Latency from a pixel_en pulse to the new x is 1 clk.
- hsync is asserted when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. vsync changes together with x = 0.
- line_start / frame_start are one clk wide, not one pixel wide.
- en low: phase, x, y and all sync levels hold; pixel_en = 0; marker pulses = 0; pixel_clk holds.
- Elaboration-time check: PIXEL_MHZ > CLK_MHZ/2, or any zero-width sync, is a $fatal.

Optional Feature:
- Macro VIDEO_TIMING_GEN_PATTERN_EN.
- Defined: internal colour-bar generator.
  - 8 vertical bars, each H_ACTIVE/8 wide; bar index b = x / (H_ACTIVE/8), saturated at 7.
  - red = all-ones if b[2], green = all-ones if b[1], blue = all-ones if b[0]; zero when de = 0.
  - Registered with the same timing as de.
- Undefined: red/green/blue tied to 0; no pattern logic is synthesised.

Decomposition:
- Package video_timing_pkg: mode struct (active/fp/sync/bp for one axis), localparam presets MODE_640x480_60 and MODE_800x600_60, and a function to compute totals.
- One natural sub-module: fractional_clk_en (phase accumulator producing pixel_en/pixel_clk), reused by other boards.
- Axis counter and sync compare stay inline.

Test Plan:
- Defaults, run 2 frames -> pixel_en every 5 clk; line period = 4000 clk; frame period = 2,100,000 clk; hsync low for x 656..751; vsync low for y 490..491; de high for 640x480 pixels per frame.
- CLK_MHZ=100, PIXEL_MHZ=40 -> exactly 2 pixel_en pulses in every 5-clk window; 400,000 pulses over 1,000,000 clk.
- H_SYNC_POL=1, V_SYNC_POL=1 -> hsync/vsync idle 0 and pulse 1; widths 96 pixels and 2 lines unchanged.
- Drop rst_n at x=300, y=200 -> same-cycle outputs at reset values; after release, the first frame_start occurs with the first counter update, and x counts from 0.
- en low for 50 clk mid-line -> x/y/hsync frozen, no pixel_en; resume continues from the same x with no skipped count.
- PATTERN_EN defined, x=0/80/639 with de=1 -> RGB = 000 / 001 / 111 (all-ones channels); RGB = 0 at x=700.
